mesi_snoop_responder: RTL and testbench
=======================================

Name: mesi_snoop_responder

Overview:
Snoop-side responder of the MESI protocol. It is the other end of the bus requests (read_miss, write_miss, invalidate) that each processor's MESI controller issues. One instance sits beside each processor's 4-line direct-mapped cache. It watches bus transactions from other processors, looks up the addressed line, and answers with shared/abort indications. It writes back Modified data to memory and downgrades or invalidates the local line state.

Parameters:
MY_ID, 0, processor number of this instance (0..2, selected by switches 17-15 at top level)
ADDR_W, 3, bus address width
DATA_W, 3, cache data word width
INDEX_W, 2, line index width; tag width is ADDR_W-INDEX_W

Ports:
clock  in  1  system clock, rising edge
reset  in  1  synchronous, active-high reset
bus_valid  in  1  bus request present
bus_op  in  2  0=read_miss, 1=write_miss, 2=invalidate, 3=reserved (treated as no-op)
bus_addr  in  ADDR_W  request address
bus_src  in  2  requesting processor id
bus_ready  out  1  responder idle and accepting a request
line_index  out  INDEX_W  cache lookup index, equal to latched addr[INDEX_W-1:0]
line_tag  in  ADDR_W-INDEX_W  tag of the indexed line
line_state  in  2  state of the indexed line: 0=I, 1=S, 2=M, 3=E
line_data  in  DATA_W  data of the indexed line
upd_en  out  1  one-cycle pulse that writes upd_state into the indexed line
upd_state  out  2  new line state
wb_valid  out  1  write-back request to memory
wb_addr  out  ADDR_W  write-back address
wb_data  out  DATA_W  write-back data
wb_ack  in  1  memory accepted the write-back
resp_valid  out  1  one-cycle response pulse
resp_shared  out  1  a valid copy remains in this cache (requester must go S, not E)
resp_abort  out  1  requester must abort and retry after the write-back
cpu_stall  out  1  local processor must not access the cache

Behaviour:
- Reset: on any clock edge with reset=1, FSM goes to IDLE. Outputs: bus_ready=1, all other outputs 0, latches cleared. Reset mid-transaction abandons the transaction, including a pending write-back; no upd_en is issued.
- FSM states: IDLE, LOOKUP, WRITEBACK, UPDATE, RESPOND.
- IDLE:
  - bus_ready=1, cpu_stall=0.
  - If bus_valid=1, bus_src!=MY_ID and bus_op!=3: latch bus_op and bus_addr, then go to LOOKUP.
  - Own requests (bus_src==MY_ID) and reserved ops are ignored: no response, stay IDLE.
- cpu_stall=1 and bus_ready=0 in every state except IDLE.
- LOOKUP (1 cycle):
  - hit = (line_state!=0) and (line_tag == latched tag).
  - Latch line_data and line_state.
  - Miss: resp_shared=0, resp_abort=0, go to RESPOND.
- Hit decisions, with next state and line update:
  - S, read_miss: shared=1, no update, go to RESPOND.
  - S, write_miss or invalidate: shared=0, upd_state=I, go to UPDATE.
  - E, read_miss: shared=1, upd_state=S, go to UPDATE.
  - E, write_miss or invalidate: shared=0, upd_state=I, go to UPDATE.
  - M, read_miss: abort=1, shared=1, upd_state=S, go to WRITEBACK.
  - M, write_miss or invalidate: abort=1, shared=0, upd_state=I, go to WRITEBACK. Invalidate on M is handled identically to write_miss.
- WRITEBACK:
  - wb_valid=1, wb_addr=latched addr, wb_data=latched data.
  - All three are held stable until wb_ack=1 is sampled; then go to UPDATE.
  - wb_ack sampled in any other state is ignored.
  - resp_abort is held at 1 throughout WRITEBACK, UPDATE and RESPOND.
- UPDATE (1 cycle): upd_en=1, upd_state as decided; go to RESPOND.
- RESPOND (1 cycle): resp_valid=1 with the final resp_shared and resp_abort; go to IDLE.
- resp_shared and resp_abort are 0 whenever the FSM is not in RESPOND, except that resp_abort stays asserted as described under WRITEBACK.
- Latency, measured from the accept edge (cycle 0):
  - miss, or S with read_miss: resp_valid in cycle 2.
  - hit with a state change: upd_en in cycle 2, resp_valid in cycle 3.
  - M hit: wb_valid from cycle 2; upd_en one cycle after wb_ack is sampled; resp_valid one cycle after upd_en.
- bus_valid while busy: not accepted and not queued. The requester holds the request until it sees bus_ready=1.
- Back-to-back requests: a new request can be accepted in the IDLE cycle right after RESPOND.

Test Plan:
- Reset, then MY_ID=0, line 1 in state E with tag 1; bus read_miss addr=3'b101 from src 1 -> cycle 2 upd_en=1 with upd_state=S; cycle 3 resp_valid=1, resp_shared=1, resp_abort=0.
- Line 2 in state M, tag 0, data 3'b110; write_miss addr=3'b010 from src 2; wb_ack held until cycle 5 -> wb_valid from cycle 2 to cycle 5 with wb_addr=010 and wb_data=110; upd_en with I in cycle 6; resp_valid=1, resp_abort=1, resp_shared=0 in cycle 7.
- Line in state S; invalidate to that address -> upd_state=I, resp_shared=0. Line in state S; read_miss to it -> no upd_en, resp_valid in cycle 2 with shared=1.
- Tag mismatch on a valid line, read_miss -> no upd_en and no wb_valid; resp_valid in cycle 2 with shared=0, abort=0.
- Request with bus_src==MY_ID, or bus_op=3 -> bus_ready stays 1; no resp_valid, upd_en or wb_valid.
- Reset asserted during WRITEBACK -> on the next edge wb_valid=0 and bus_ready=1; no upd_en or resp_valid follows. A second bus_valid presented during LOOKUP is not accepted.

Source files
------------

// File: rtl/mesi_snoop_responder_if.sv
// Bus, cache-port and write-back signals of one MESI snoop responder.
// The responder uses the slave modport; the bus/cache/memory side uses master.
interface mesi_snoop_responder_if #(
    parameter int ADDR_W  = 3,
    parameter int DATA_W  = 3,
    parameter int INDEX_W = 2
);
    logic                      bus_valid;
    logic [1:0]                bus_op;
    logic [ADDR_W-1:0]         bus_addr;
    logic [1:0]                bus_src;
    logic                      bus_ready;

    logic [INDEX_W-1:0]        line_index;
    logic [ADDR_W-INDEX_W-1:0] line_tag;
    logic [1:0]                line_state;
    logic [DATA_W-1:0]         line_data;
    logic                      upd_en;
    logic [1:0]                upd_state;

    logic                      wb_valid;
    logic [ADDR_W-1:0]         wb_addr;
    logic [DATA_W-1:0]         wb_data;
    logic                      wb_ack;

    logic                      resp_valid;
    logic                      resp_shared;
    logic                      resp_abort;
    logic                      cpu_stall;

    modport slave (
        input  bus_valid, bus_op, bus_addr, bus_src,
        output bus_ready,
        output line_index,
        input  line_tag, line_state, line_data,
        output upd_en, upd_state,
        output wb_valid, wb_addr, wb_data,
        input  wb_ack,
        output resp_valid, resp_shared, resp_abort, cpu_stall
    );

    modport master (
        output bus_valid, bus_op, bus_addr, bus_src,
        input  bus_ready,
        input  line_index,
        output line_tag, line_state, line_data,
        input  upd_en, upd_state,
        input  wb_valid, wb_addr, wb_data,
        output wb_ack,
        input  resp_valid, resp_shared, resp_abort, cpu_stall
    );
endinterface

// File: rtl/mesi_snoop_responder.sv
// MESI snoop responder: looks up other processors' bus requests in the local
// 4-line cache, writes back Modified data, downgrades/invalidates, and answers.
module mesi_snoop_responder #(
    parameter int MY_ID   = 0,
    parameter int ADDR_W  = 3,
    parameter int DATA_W  = 3,
    parameter int INDEX_W = 2
) (
    input  logic                  clock,
    input  logic                  reset,
    mesi_snoop_responder_if.slave snp
);
    localparam logic [1:0] MY_SRC  = 2'(MY_ID);
    localparam logic [1:0] OP_READ = 2'd0;
    localparam logic [1:0] OP_RSVD = 2'd3;

    localparam logic [1:0] LS_I = 2'd0;
    localparam logic [1:0] LS_S = 2'd1;
    localparam logic [1:0] LS_M = 2'd2;
    localparam logic [1:0] LS_E = 2'd3;

    typedef enum logic [2:0] {
        IDLE,
        LOOKUP,
        WRITEBACK,
        UPDATE,
        RESPOND
    } state_e;

    state_e                state_q;
    logic [1:0]            op_q;
    logic [ADDR_W-1:0]     addr_q;
    logic [DATA_W-1:0]     data_q;
    logic [1:0]            new_state_q;
    logic                  shared_q;

    logic                  bus_ready_q;
    logic                  cpu_stall_q;
    logic                  upd_en_q;
    logic [1:0]            upd_state_q;
    logic                  wb_valid_q;
    logic                  resp_valid_q;
    logic                  resp_shared_q;
    logic                  resp_abort_q;

    logic                  accept;
    logic                  hit;
    logic                  is_read;
    state_e                next_d;
    logic                  shared_d;
    logic                  abort_d;
    logic [1:0]            new_state_d;

    assign accept = snp.bus_valid && (snp.bus_src != MY_SRC) && (snp.bus_op != OP_RSVD);

    // Snoop decision for the line presented during LOOKUP.
    // NOTE: every always_comb output gets a default first so no latch is inferred.
    always_comb begin
        hit         = (snp.line_state != LS_I) && (snp.line_tag == addr_q[ADDR_W-1:INDEX_W]);
        is_read     = (op_q == OP_READ);
        next_d      = RESPOND;
        shared_d    = 1'b0;
        abort_d     = 1'b0;
        new_state_d = LS_I;
        if (hit) begin
            case (snp.line_state)
                LS_S: begin
                    if (is_read) shared_d = 1'b1;
                    else         next_d   = UPDATE;
                end
                LS_E: begin
                    next_d = UPDATE;
                    if (is_read) begin
                        shared_d    = 1'b1;
                        new_state_d = LS_S;
                    end
                end
                LS_M: begin
                    next_d  = WRITEBACK;
                    abort_d = 1'b1;
                    if (is_read) begin
                        shared_d    = 1'b1;
                        new_state_d = LS_S;
                    end
                end
                default: ;
            endcase
        end
    end

    // NOTE: state and outputs are registered with non-blocking assignments; reset is synchronous.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q       <= IDLE;
            op_q          <= '0;
            addr_q        <= '0;
            data_q        <= '0;
            new_state_q   <= LS_I;
            shared_q      <= 1'b0;
            bus_ready_q   <= 1'b1;
            cpu_stall_q   <= 1'b0;
            upd_en_q      <= 1'b0;
            upd_state_q   <= LS_I;
            wb_valid_q    <= 1'b0;
            resp_valid_q  <= 1'b0;
            resp_shared_q <= 1'b0;
            resp_abort_q  <= 1'b0;
        end else begin
            upd_en_q      <= 1'b0;
            upd_state_q   <= LS_I;
            resp_valid_q  <= 1'b0;
            resp_shared_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (accept) begin
                        op_q        <= snp.bus_op;
                        addr_q      <= snp.bus_addr;
                        bus_ready_q <= 1'b0;
                        cpu_stall_q <= 1'b1;
                        state_q     <= LOOKUP;
                    end
                end
                LOOKUP: begin
                    data_q       <= snp.line_data;
                    new_state_q  <= new_state_d;
                    shared_q     <= shared_d;
                    resp_abort_q <= abort_d;
                    state_q      <= next_d;
                    case (next_d)
                        WRITEBACK: wb_valid_q <= 1'b1;
                        UPDATE: begin
                            upd_en_q    <= 1'b1;
                            upd_state_q <= new_state_d;
                        end
                        default: begin
                            resp_valid_q  <= 1'b1;
                            resp_shared_q <= shared_d;
                        end
                    endcase
                end
                WRITEBACK: begin
                    // Address and data stay on the latches until memory takes them.
                    if (snp.wb_ack) begin
                        wb_valid_q  <= 1'b0;
                        upd_en_q    <= 1'b1;
                        upd_state_q <= new_state_q;
                        state_q     <= UPDATE;
                    end
                end
                UPDATE: begin
                    resp_valid_q  <= 1'b1;
                    resp_shared_q <= shared_q;
                    state_q       <= RESPOND;
                end
                RESPOND: begin
                    bus_ready_q  <= 1'b1;
                    cpu_stall_q  <= 1'b0;
                    resp_abort_q <= 1'b0;
                    state_q      <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign snp.bus_ready   = bus_ready_q;
    assign snp.cpu_stall   = cpu_stall_q;
    assign snp.line_index  = addr_q[INDEX_W-1:0];
    assign snp.upd_en      = upd_en_q;
    assign snp.upd_state   = upd_state_q;
    assign snp.wb_valid    = wb_valid_q;
    assign snp.wb_addr     = addr_q;
    assign snp.wb_data     = data_q;
    assign snp.resp_valid  = resp_valid_q;
    assign snp.resp_shared = resp_shared_q;
    assign snp.resp_abort  = resp_abort_q;
endmodule

// File: tb/tb_mesi_snoop_responder.sv
// Bench for mesi_snoop_responder: the bench owns the 4-line cache and predicts
// every output cycle from the MESI snoop rules, plus directed literal checks.
module tb_mesi_snoop_responder;
    localparam int MY_ID = 0;

    logic clock = 1'b0;
    logic reset = 1'b1;
    always #5 clock = ~clock;

    mesi_snoop_responder_if #(.ADDR_W(3), .DATA_W(3), .INDEX_W(2)) ifc ();

    mesi_snoop_responder #(.MY_ID(MY_ID), .ADDR_W(3), .DATA_W(3), .INDEX_W(2)) dut (
        .clock (clock),
        .reset (reset),
        .snp   (ifc)
    );

    typedef struct packed {
        logic       ready;
        logic       stall;
        logic [1:0] idx;
        logic       upd;
        logic [1:0] ust;
        logic       wb;
        logic [2:0] waddr;
        logic [2:0] wdata;
        logic       rv;
        logic       rsh;
        logic       rab;
    } obs_t;

    typedef struct {
        obs_t       e;
        bit         ack;
        bit         apply;
        logic [1:0] aidx;
        logic [1:0] ast;
    } step_t;

    // Cache contents seen by the responder (0=I 1=S 2=M 3=E).
    logic       c_tag  [4];
    logic [1:0] c_st   [4];
    logic [2:0] c_data [4];

    assign ifc.line_tag   = c_tag[ifc.line_index];
    assign ifc.line_state = c_st[ifc.line_index];
    assign ifc.line_data  = c_data[ifc.line_index];

    step_t      pend[$];
    obs_t       exp_q[$];
    int         n_vec = 0;
    int         n_bad = 0;
    int         cyc = 0;
    logic [1:0] last_idx = 2'd0;
    string      phase = "reset";

    function automatic obs_t idle_obs();
        obs_t o;
        o       = '0;
        o.ready = 1'b1;
        o.idx   = last_idx;
        return o;
    endfunction

    function automatic obs_t sample();
        obs_t o;
        o.ready = ifc.bus_ready;
        o.stall = ifc.cpu_stall;
        o.idx   = ifc.line_index;
        o.upd   = ifc.upd_en;
        o.ust   = ifc.upd_state;
        o.wb    = ifc.wb_valid;
        o.waddr = ifc.wb_addr;
        o.wdata = ifc.wb_data;
        o.rv    = ifc.resp_valid;
        o.rsh   = ifc.resp_shared;
        o.rab   = ifc.resp_abort;
        return o;
    endfunction

    function automatic obs_t masked(obs_t o, obs_t e);
        if (!e.upd) o.ust = '0;
        if (!e.wb) begin
            o.waddr = '0;
            o.wdata = '0;
        end
        return o;
    endfunction

    function automatic string fmt(obs_t o);
        return $sformatf("rdy=%b stl=%b idx=%0d upd=%b/%0d wb=%b/%0d/%0d rv=%b sh=%b ab=%b",
                         o.ready, o.stall, o.idx, o.upd, o.ust, o.wb, o.waddr, o.wdata,
                         o.rv, o.rsh, o.rab);
    endfunction

    task automatic check(input string name, input logic [7:0] got, input logic [7:0] want);
        n_vec++;
        if (got !== want) begin
            n_bad++;
            $display("FAIL %s cycle %0d: got %0d required %0d", name, cyc, got, want);
        end
    endtask

    // Predict the whole transaction from the line contents and the MESI rules.
    task automatic plan(input logic [1:0] op, input logic [2:0] addr, input int dly);
        logic [1:0] i;
        bit         hit, rd, upd, wb, sh;
        logic [1:0] ns;
        step_t      s;
        obs_t       base;
        i   = addr[1:0];
        hit = (c_st[i] != 2'd0) && (c_tag[i] == addr[2]);
        rd  = (op == 2'd0);
        upd = 1'b0; wb = 1'b0; sh = 1'b0; ns = 2'd0;
        if (hit) begin
            sh  = rd;
            ns  = rd ? 2'd1 : 2'd0;
            upd = !(c_st[i] == 2'd1 && rd);
            wb  = (c_st[i] == 2'd2);
        end
        base       = '0;
        base.stall = 1'b1;
        base.idx   = i;
        s.e = base; s.ack = 1'b0; s.apply = 1'b0; s.aidx = i; s.ast = ns;
        pend.push_back(s);
        if (wb) begin
            for (int k = 0; k <= dly; k++) begin
                s.e       = base;
                s.e.wb    = 1'b1;
                s.e.waddr = addr;
                s.e.wdata = c_data[i];
                s.e.rab   = 1'b1;
                s.ack     = (k == dly);
                pend.push_back(s);
            end
        end
        s.ack = 1'b0;
        if (upd) begin
            s.e     = base;
            s.e.upd = 1'b1;
            s.e.ust = ns;
            s.e.rab = wb;
            pend.push_back(s);
        end
        s.e       = base;
        s.e.rv    = 1'b1;
        s.e.rsh   = sh;
        s.e.rab   = wb;
        s.apply   = upd;
        pend.push_back(s);
    endtask

    // One clock cycle: publish this cycle's expectation, then drive inputs.
    task automatic tick(input bit rst, input bit v, input logic [1:0] op, input logic [2:0] addr,
                        input logic [1:0] src, input int dly, input bit mut);
        step_t      s;
        bit         busy;
        logic [1:0] m;
        @(posedge clock);
        #1;
        cyc++;
        busy = (pend.size() > 0);
        if (busy) s = pend.pop_front();
        else begin
            s.e = idle_obs(); s.ack = 1'b0; s.apply = 1'b0; s.aidx = 2'd0; s.ast = 2'd0;
        end
        exp_q.push_back(s.e);
        if (s.apply) c_st[s.aidx] = s.ast;
        if (!busy && mut) begin
            m         = 2'($urandom);
            c_tag[m]  = 1'($urandom);
            c_st[m]   = 2'($urandom);
            c_data[m] = 3'($urandom);
        end
        reset         = rst;
        ifc.bus_valid = v;
        ifc.bus_op    = op;
        ifc.bus_addr  = addr;
        ifc.bus_src   = src;
        ifc.wb_ack    = s.e.wb ? s.ack : 1'($urandom_range(0, 1));
        if (rst) begin
            pend.delete();
            last_idx = 2'd0;
        end else if (!busy && v && src != 2'(MY_ID) && op != 2'd3) begin
            plan(op, addr, dly);
            last_idx = addr[1:0];
        end
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) tick(1'b0, 1'b0, 2'd0, 3'd0, 2'd0, 0, 1'b0);
    endtask

    initial begin : compare
        obs_t e, a;
        forever begin
            @(negedge clock);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                a = sample();
                n_vec++;
                if (masked(a, e) !== masked(e, e)) begin
                    n_bad++;
                    $display("FAIL %s cycle %0d: got %s expected %s", phase, cyc, fmt(a), fmt(e));
                end
            end
        end
    end

    initial begin : stimulus
        for (int i = 0; i < 4; i++) begin
            c_tag[i] = 1'b0; c_st[i] = 2'd0; c_data[i] = 3'd0;
        end
        ifc.bus_valid = 1'b0; ifc.bus_op = 2'd0; ifc.bus_addr = 3'd0;
        ifc.bus_src = 2'd0; ifc.wb_ack = 1'b0;
        repeat (2) @(posedge clock);
        tick(1'b1, 1'b0, 2'd0, 3'd0, 2'd0, 0, 1'b0);
        check("reset outputs", 8'({ifc.bus_ready, ifc.cpu_stall, ifc.upd_en, ifc.wb_valid,
                                  ifc.resp_valid, ifc.resp_shared, ifc.resp_abort}), 8'd64);
        idle(1);

        phase = "E read_miss";
        c_tag[1] = 1'b1; c_st[1] = 2'd3; c_data[1] = 3'b011;
        tick(1'b0, 1'b1, 2'd0, 3'b101, 2'd1, 0, 1'b0);
        tick(1'b0, 1'b1, 2'd1, 3'b101, 2'd2, 0, 1'b0);
        check("busy during lookup", 8'(ifc.bus_ready), 8'd0);
        tick(1'b0, 1'b0, 2'd0, 3'd0, 2'd0, 0, 1'b0);
        check("E read upd", 8'({ifc.upd_en, ifc.upd_state}), 8'd5);
        tick(1'b0, 1'b0, 2'd0, 3'd0, 2'd0, 0, 1'b0);
        check("E read resp", 8'({ifc.resp_valid, ifc.resp_shared, ifc.resp_abort}), 8'd6);
        tick(1'b0, 1'b0, 2'd0, 3'd0, 2'd0, 0, 1'b0);
        check("E read back idle", 8'(ifc.bus_ready), 8'd1);

        phase = "M write_miss";
        c_tag[2] = 1'b0; c_st[2] = 2'd2; c_data[2] = 3'b110;
        tick(1'b0, 1'b1, 2'd1, 3'b010, 2'd2, 3, 1'b0);
        idle(2);
        check("M wb start", 8'({ifc.wb_valid, ifc.wb_addr, ifc.wb_data}), 8'd86);
        check("M abort held", 8'(ifc.resp_abort), 8'd1);
        idle(3);
        check("M wb held", 8'({ifc.wb_valid, ifc.wb_addr, ifc.wb_data}), 8'd86);
        idle(1);
        check("M upd", 8'({ifc.upd_en, ifc.upd_state}), 8'd4);
        idle(1);
        check("M resp", 8'({ifc.resp_valid, ifc.resp_shared, ifc.resp_abort}), 8'd5);
        idle(1);

        phase = "S invalidate";
        c_tag[3] = 1'b1; c_st[3] = 2'd1; c_data[3] = 3'b001;
        tick(1'b0, 1'b1, 2'd2, 3'b111, 2'd1, 0, 1'b0);
        idle(2);
        check("S inv upd", 8'({ifc.upd_en, ifc.upd_state}), 8'd4);
        idle(1);
        check("S inv resp", 8'({ifc.resp_valid, ifc.resp_shared, ifc.resp_abort}), 8'd4);
        idle(1);

        phase = "S read_miss";
        c_tag[0] = 1'b0; c_st[0] = 2'd1; c_data[0] = 3'b111;
        tick(1'b0, 1'b1, 2'd0, 3'b000, 2'd2, 0, 1'b0);
        idle(2);
        check("S read resp", 8'({ifc.resp_valid, ifc.resp_shared, ifc.resp_abort, ifc.upd_en}), 8'd12);
        idle(1);

        phase = "tag miss";
        tick(1'b0, 1'b1, 2'd0, 3'b001, 2'd1, 0, 1'b0);
        idle(2);
        check("miss resp", 8'({ifc.resp_valid, ifc.resp_shared, ifc.resp_abort,
                               ifc.upd_en, ifc.wb_valid}), 8'd16);
        idle(1);

        phase = "ignored";
        tick(1'b0, 1'b1, 2'd0, 3'b101, 2'(MY_ID), 0, 1'b0);
        tick(1'b0, 1'b1, 2'd3, 3'b101, 2'd1, 0, 1'b0);
        check("own req ignored", 8'({ifc.bus_ready, ifc.resp_valid, ifc.upd_en, ifc.wb_valid}), 8'd8);
        idle(2);
        check("rsvd op ignored", 8'({ifc.bus_ready, ifc.resp_valid, ifc.upd_en, ifc.wb_valid}), 8'd8);

        phase = "reset in writeback";
        c_tag[2] = 1'b1; c_st[2] = 2'd2; c_data[2] = 3'b101;
        tick(1'b0, 1'b1, 2'd0, 3'b110, 2'd2, 8, 1'b0);
        idle(2);
        check("wb before reset", 8'(ifc.wb_valid), 8'd1);
        tick(1'b1, 1'b0, 2'd0, 3'd0, 2'd0, 0, 1'b0);
        tick(1'b0, 1'b0, 2'd0, 3'd0, 2'd0, 0, 1'b0);
        check("wb abandoned", 8'({ifc.wb_valid, ifc.bus_ready}), 8'd1);
        idle(10);
        check("nothing after reset", 8'({ifc.resp_valid, ifc.upd_en, ifc.wb_valid}), 8'd0);

        phase = "random";
        for (int n = 0; n < 4000; n++) begin
            bit         rst, v, mut;
            logic [1:0] op, src;
            logic [2:0] addr;
            int         dly;
            rst  = ($urandom % 400) == 0;
            v    = ($urandom % 4) != 0;
            op   = 2'($urandom);
            src  = 2'($urandom);
            addr = 3'($urandom);
            dly  = int'($urandom % 4);
            mut  = ($urandom % 5) == 0;
            tick(rst, v, op, addr, src, dly, mut);
        end
        idle(10);
        @(negedge clock);
        #1;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
